pc_sequencer: RTL and testbench

//  Owns the MIPS32 fetch-stage PC register and decides the next fetch address each cycle:

---
 rtl/mips_pkg.sv | 22 ++
 rtl/pc_incrementer.sv | 13 +
 rtl/pc_sequencer.sv | 109 ++++++++++
 tb/tb_pc_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS32 fetch-stage definitions: PC width, default vectors and the
// pc_sequencer state encoding.
package mips_pkg;

   localparam int unsigned PC_W = 32;

   localparam logic [PC_W-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
   localparam logic [PC_W-1:0] EXC_VECTOR_DEF   = 32'h0000_0180;
   localparam logic [PC_W-1:0] PC_STEP_DEF      = 32'd4;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HOLD   = 2'd2,
      BUBBLE = 2'd3
   } pc_state_t;

   function automatic logic is_misaligned(input logic [PC_W-1:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/pc_incrementer.sv
// Sequential-fetch adder: pc + STEP, modulo 2^32 with no carry out.
module pc_incrementer
   import mips_pkg::*;
#(
   parameter logic [PC_W-1:0] STEP = PC_STEP_DEF
) (
   input  logic [PC_W-1:0] pc_i,
   output logic [PC_W-1:0] pc_next_o
);

   assign pc_next_o = pc_i + STEP;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC owner: picks sequential, branch, jump, exception or held PC
// each cycle, raises the IF squash on redirects and counts stalled cycles.
module pc_sequencer
   import mips_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
   parameter logic [PC_W-1:0] EXC_VECTOR   = EXC_VECTOR_DEF,
   parameter logic [PC_W-1:0] PC_STEP      = PC_STEP_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] branch_target,
   input  logic            jump,
   input  logic [PC_W-1:0] jump_target,
   input  logic            exception,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] pc_plus4,
   output logic            fetch_valid,
   output logic            flush_if,
   output logic            addr_err,
   output logic [31:0]     stall_count
);

   pc_state_t       state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            addr_err_q, addr_err_d;
   logic [31:0]     stall_count_q, stall_count_d;
   logic            flush_d;
   logic [PC_W-1:0] redirect_target;

   pc_incrementer #(.STEP(PC_STEP)) u_incr (
      .pc_i      (pc_q),
      .pc_next_o (pc_plus4)
   );

   // Branch is older in the pipe than a jump, so it wins a same-cycle collision.
   assign redirect_target = branch_taken ? branch_target : jump_target;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      addr_err_d    = 1'b0;
      stall_count_d = stall_count_q;
      flush_d       = 1'b0;
      unique case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN, HOLD: begin
            if (exception) begin
               pc_d    = EXC_VECTOR;
               flush_d = 1'b1;
               state_d = BUBBLE;
            end else if (branch_taken || jump) begin
               flush_d = 1'b1;
               state_d = BUBBLE;
               if (is_misaligned(redirect_target)) begin
                  pc_d       = EXC_VECTOR;
                  addr_err_d = 1'b1;
               end else begin
                  pc_d = redirect_target;
               end
            end else if (stall) begin
               state_d = HOLD;
               if (stall_count_q != 32'hFFFF_FFFF) begin
                  stall_count_d = stall_count_q + 32'd1;
               end
            end else begin
               pc_d    = pc_plus4;
               state_d = RUN;
            end
         end
         BUBBLE: begin
            // Branch/jump/stall here belong to the squashed path; only exceptions count.
            if (exception) begin
               pc_d    = EXC_VECTOR;
               flush_d = 1'b1;
               state_d = BUBBLE;
            end else begin
               state_d = RUN;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= BOOT;
         pc_q          <= RESET_VECTOR;
         addr_err_q    <= 1'b0;
         stall_count_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         addr_err_q    <= addr_err_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign pc          = pc_q;
   assign fetch_valid = (state_q == RUN) || (state_q == HOLD);
   assign flush_if    = flush_d & ~rst;
   assign addr_err    = addr_err_q;
   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a per-cycle behavioural model plus
// directed scenarios with literal expectations.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic        exception;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_valid;
   logic        flush_if;
   logic        addr_err;
   logic [31:0] stall_count;

   int checks = 0;
   int errors = 0;

   pc_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .exception     (exception),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .fetch_valid   (fetch_valid),
      .flush_if      (flush_if),
      .addr_err      (addr_err),
      .stall_count   (stall_count)
   );

   always #5 clk = ~clk;

   // Behavioural model: "starting up", "waiting for imem after redirect", or fetching.
   bit          m_on = 1'b0;
   bit          m_boot;
   bit          m_bubble;
   bit          m_err;
   logic [31:0] m_pc;
   logic [31:0] m_stalls;

   always @(posedge clk) begin
      logic [31:0] tgt;
      if (rst) begin
         m_on = 1'b1; m_boot = 1'b1; m_bubble = 1'b0; m_err = 1'b0;
         m_pc = 32'h0; m_stalls = 32'h0;
      end else if (m_on) begin
         m_err = 1'b0;
         if (m_boot) begin
            m_boot = 1'b0;
         end else if (m_bubble) begin
            if (exception) m_pc = 32'h180;
            else m_bubble = 1'b0;
         end else if (exception) begin
            m_pc = 32'h180; m_bubble = 1'b1;
         end else if (branch_taken || jump) begin
            tgt = branch_taken ? branch_target : jump_target;
            m_bubble = 1'b1;
            if (tgt % 4 != 0) begin
               m_pc = 32'h180; m_err = 1'b1;
            end else begin
               m_pc = tgt;
            end
         end else if (stall) begin
            if (m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
         end else begin
            m_pc = m_pc + 4;
         end
      end
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (m_on) begin
         cmp("model_pc", pc, m_pc);
         cmp("model_pc_plus4", pc_plus4, m_pc + 32'd4);
         cmp("model_fetch_valid", {31'd0, fetch_valid}, {31'd0, !m_boot && !m_bubble});
         cmp("model_flush_if", {31'd0, flush_if},
             {31'd0, !rst && !m_boot && (exception || (!m_bubble && (branch_taken || jump)))});
         cmp("model_addr_err", {31'd0, addr_err}, {31'd0, m_err});
         cmp("model_stall_count", stall_count, m_stalls);
         $display("cycle t=%0t pc=%h fv=%0b flush=%0b aerr=%0b stalls=%0d",
                  $time, pc, fetch_valid, flush_if, addr_err, stall_count);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall = 0; branch_taken = 0; jump = 0; exception = 0;
   endtask

   initial begin
      rst = 1; idle(); branch_target = 0; jump_target = 0;
      // T1 reset
      cyc(); cyc();
      cmp("t1_pc_reset", pc, 32'h0);
      cmp("t1_fv_reset", {31'd0, fetch_valid}, 32'd0);
      cmp("t1_flush_in_rst", {31'd0, flush_if}, 32'd0);
      cmp("t1_stalls_reset", stall_count, 32'd0);
      rst = 0;
      cyc();
      cmp("t1_boot_pc", pc, 32'h0);
      cmp("t1_boot_fv", {31'd0, fetch_valid}, 32'd1);
      cyc(); cmp("t1_pc4", pc, 32'h4);
      cyc(); cmp("t1_pc8", pc, 32'h8);
      cyc(); cmp("t1_pcC", pc, 32'hC);
      // T2 stall
      cyc(); cmp("t2_pc10", pc, 32'h10);
      stall = 1;
      cyc(); cyc(); cyc();
      cmp("t2_pc_held", pc, 32'h10);
      cmp("t2_stall_count", stall_count, 32'd3);
      stall = 0;
      cyc(); cmp("t2_pc14", pc, 32'h14);
      // T3 branch+jump collision
      cyc(); cyc(); cyc();
      cmp("t3_pc20", pc, 32'h20);
      branch_taken = 1; branch_target = 32'h100; jump = 1; jump_target = 32'h200;
      #1 cmp("t3_flush", {31'd0, flush_if}, 32'd1);
      cyc(); idle();
      cmp("t3_pc_target", pc, 32'h100);
      cmp("t3_bubble_fv", {31'd0, fetch_valid}, 32'd0);
      cyc(); cmp("t3_fv_back", {31'd0, fetch_valid}, 32'd1);
      cyc(); cmp("t3_pc104", pc, 32'h104);
      // T4 misaligned jump, concurrent stall must not count
      jump = 1; jump_target = 32'h202; stall = 1;
      cyc(); idle();
      cmp("t4_pc_exc", pc, 32'h180);
      cmp("t4_addr_err", {31'd0, addr_err}, 32'd1);
      cmp("t4_stall_count", stall_count, 32'd3);
      jump = 1; jump_target = 32'h300; stall = 1;   // ignored in the bubble
      cyc(); idle();
      cmp("t4_addr_err_clr", {31'd0, addr_err}, 32'd0);
      cmp("t4_pc_ignored", pc, 32'h180);
      cmp("t4_stall_ignored", stall_count, 32'd3);
      // T5 exception in bubble
      branch_taken = 1; branch_target = 32'h40;
      cyc(); idle();
      cmp("t5_pc40", pc, 32'h40);
      exception = 1;
      #1 cmp("t5_flush_bubble", {31'd0, flush_if}, 32'd1);
      cyc(); idle();
      cmp("t5_pc_exc", pc, 32'h180);
      cmp("t5_second_bubble", {31'd0, fetch_valid}, 32'd0);
      cyc(); cmp("t5_run_fv", {31'd0, fetch_valid}, 32'd1);
      cyc(); cmp("t5_pc184", pc, 32'h184);
      // T6 wrap and reset mid-bubble
      jump = 1; jump_target = 32'hFFFF_FFFC;
      cyc(); idle();
      cyc();
      cmp("t6_pc_top", pc, 32'hFFFF_FFFC);
      cmp("t6_plus4_wrap", pc_plus4, 32'h0);
      cyc(); cmp("t6_pc_wrapped", pc, 32'h0);
      stall = 1;
      cyc(); idle();
      cmp("t6_stall_count", stall_count, 32'd4);
      branch_taken = 1; branch_target = 32'h80;
      cyc(); idle();
      rst = 1; exception = 1;
      #1 cmp("t6_flush_rst", {31'd0, flush_if}, 32'd0);
      cyc(); rst = 0; idle();
      cmp("t6_pc_reset", pc, 32'h0);
      cmp("t6_fv_reset", {31'd0, fetch_valid}, 32'd0);
      cmp("t6_stalls_reset", stall_count, 32'd0);
      cyc(); cyc();
      cmp("t6_pc_after", pc, 32'h4);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout t=%0t actual=running required=finished", $time);
      $fatal(1, "timeout");
   end

endmodule
